hba_arbiter: RTL and testbench
==============================

HBA_ARBITER -- requirements
Module: hba_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2: number of HBA bus masters, legal range 1..8.
REQ-002 SHALL have parameter DBUS_WIDTH, default 8: data bus width.
REQ-003 SHALL have parameter PERIPH_ADDR_WIDTH, default 4: peripheral-select address bits.
REQ-004 SHALL have parameter REG_ADDR_WIDTH, default 8: register address bits.
REQ-005 SHALL have parameter ADDR_WIDTH, default PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH: full address width.
REQ-006 SHALL have port hba_clk, input, 1 bit: the single clock; all logic rises on this edge.
REQ-007 SHALL have port hba_reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port master_request, input, NUM_MASTERS bits: per-master bus request.
REQ-009 SHALL have port master_abus, input, NUM_MASTERS*ADDR_WIDTH bits: master i address at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 SHALL have port master_rnw, input, NUM_MASTERS bits: per-master read-not-write.
REQ-011 SHALL have port master_select, input, NUM_MASTERS bits: per-master transfer in progress.
REQ-012 SHALL have port master_dbus, input, NUM_MASTERS*DBUS_WIDTH bits: master i write data at [i*DBUS_WIDTH +: DBUS_WIDTH].
REQ-013 SHALL have port hba_mgrant, output, NUM_MASTERS bits: one-hot or zero grant.
REQ-014 SHALL have port hba_abus, output, ADDR_WIDTH bits: arbitrated address to slaves.
REQ-015 SHALL have port hba_rnw, output, 1 bit: arbitrated read-not-write.
REQ-016 SHALL have port hba_select, output, 1 bit: arbitrated transfer in progress.
REQ-017 SHALL have port hba_dbus, output, DBUS_WIDTH bits: arbitrated write data.
REQ-018 SHALL have port hba_xferack, input, 1 bit: slave transfer acknowledge, used for transfer tracking.

Function
REQ-019 SHALL implement two states, IDLE and OWNED, plus a registered grant vector and a round-robin priority pointer.
REQ-020 In IDLE with any master_request bit high, SHALL select the first requester at or after the pointer (wrapping modulo NUM_MASTERS), set its hba_mgrant bit on the next edge, and enter OWNED.
REQ-021 SHALL hold the grant in OWNED while the owner's master_request is high; other requests SHALL NOT preempt.
REQ-022 SHALL release ownership only on the edge where the owner's master_request is low and hba_select is low; a request drop during an active select SHALL defer release until select falls.
REQ-023 On release, SHALL clear hba_mgrant, set the pointer to owner+1 (mod NUM_MASTERS), and return to IDLE; one dead IDLE cycle SHALL separate successive grants.
REQ-024 hba_mgrant SHALL never have more than one bit set.
REQ-025 hba_abus, hba_rnw, hba_select and hba_dbus SHALL combinationally carry the owning master's fields when a grant is active, and SHALL be all-zero when no grant is active.
REQ-026 An active master_select from a non-granted master SHALL have no effect on any output.
REQ-027 SHALL track a transfer as open from the granted hba_select rising until hba_xferack; hba_select falling with no acknowledge SHALL close the transfer without error.
REQ-028 Simultaneous requests SHALL be resolved only through the pointer; the lowest index never wins unconditionally.
REQ-029 With NUM_MASTERS=1, SHALL degenerate to grant-on-request/release-on-drop with the same timing.

Reset
REQ-030 While hba_reset is high at a clock edge: state=IDLE, hba_mgrant=0, pointer=0, transfer-open flag=0, so all arbitrated outputs are zero.
REQ-031 Reset asserted mid-ownership or mid-transfer SHALL drop the grant on that edge with no further handshake; arbitration SHALL resume on the first edge after reset deasserts.

Verification
REQ-032 Reset, then master_request=2'b01 -> hba_mgrant=2'b01 one cycle later; master 0's abus=12'h012 appears on hba_abus while granted.
REQ-033 master_request=2'b11 from reset -> master 0 granted first; master 0 drops request -> one cycle with grant 2'b00, then 2'b10; master 1 drops and master 0 re-requests -> 2'b01.
REQ-034 Owner drops request while hba_select=1 -> grant held until select=0, released on that edge; other requester granted after one dead cycle.
REQ-035 Non-owner drives master_select=1 with abus=12'hFFF -> hba_select and hba_abus are unchanged, equal to the owner's fields or zero.
REQ-036 Reset pulsed while master 1 owns the bus mid-transfer -> hba_mgrant=0 and all outputs zero on that edge; after release with both requesting, master 0 wins.
REQ-037 NUM_MASTERS=4, all requesting continuously with one-cycle ownership each -> grant order 0,1,2,3,0, with no bit ever starved longer than three grants.

Source files
------------

// File: rtl/hba_arbiter.sv
// Round-robin HBA bus arbiter: grants one master at a time and muxes the
// owner's address/control/data onto the shared slave bus.
module hba_arbiter #(
    parameter int NUM_MASTERS       = 2,
    parameter int DBUS_WIDTH        = 8,
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH
) (
    input  logic                             hba_clk,
    input  logic                             hba_reset,
    input  logic [NUM_MASTERS-1:0]           master_request,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] master_abus,
    input  logic [NUM_MASTERS-1:0]           master_rnw,
    input  logic [NUM_MASTERS-1:0]           master_select,
    input  logic [NUM_MASTERS*DBUS_WIDTH-1:0] master_dbus,
    output logic [NUM_MASTERS-1:0]           hba_mgrant,
    output logic [ADDR_WIDTH-1:0]            hba_abus,
    output logic                             hba_rnw,
    output logic                             hba_select,
    output logic [DBUS_WIDTH-1:0]            hba_dbus,
    input  logic                             hba_xferack,
    output logic                             o_xfer_open
);

    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t                 r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
    logic [PW-1:0]          r_owner, w_owner_nxt;
    logic [PW-1:0]          r_ptr, w_ptr_nxt;
    logic                   r_sel_q, r_xfer_open;

    logic                   w_found;
    logic [PW-1:0]          w_pick;
    int                     w_dist, w_best;

    // Winner is the requester with the smallest circular distance from the pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_best  = NUM_MASTERS;
        w_dist  = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_dist = (i >= int'(r_ptr)) ? i - int'(r_ptr) : i + NUM_MASTERS - int'(r_ptr);
            if (master_request[i] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_found = 1'b1;
                w_pick  = PW'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = OWNED;
                    w_owner_nxt = w_pick;
                    w_grant_nxt = NUM_MASTERS'(1) << w_pick;
                end
            end
            OWNED: begin
                // An open select keeps the bus even after the request drops.
                if (!master_request[r_owner] && !hba_select) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_ptr_nxt   = (r_owner == PW'(NUM_MASTERS - 1)) ? '0 : r_owner + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_sel_q     <= 1'b0;
            r_xfer_open <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel_q <= hba_select;
            if (!hba_select || hba_xferack)
                r_xfer_open <= 1'b0;
            else if (!r_sel_q)
                r_xfer_open <= 1'b1;
        end
    end

    // One-hot AND-OR mux; a non-granted master's fields never reach the bus.
    always_comb begin
        hba_abus   = '0;
        hba_rnw    = 1'b0;
        hba_select = 1'b0;
        hba_dbus   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i]) begin
                hba_abus   = master_abus[i*ADDR_WIDTH +: ADDR_WIDTH];
                hba_rnw    = master_rnw[i];
                hba_select = master_select[i];
                hba_dbus   = master_dbus[i*DBUS_WIDTH +: DBUS_WIDTH];
            end
        end
    end

    assign hba_mgrant  = r_grant;
    assign o_xfer_open = r_xfer_open;

endmodule

// File: tb/tb_hba_arbiter.sv
// Bench for hba_arbiter: directed scenarios plus random traffic on a 2-master
// and a 4-master instance, compared against a behavioural arbitration model.
module tb_hba_arbiter;

    logic hba_clk = 1'b0;
    always #5 hba_clk = ~hba_clk;

    logic        rst;
    logic        ack;
    logic [1:0]  reqA, rnwA, selA, gntA;
    logic [23:0] abusA;
    logic [15:0] dbusA;
    logic [11:0] habusA;
    logic        hrnwA, hselA, xopenA;
    logic [7:0]  hdbusA;
    logic [3:0]  reqB, rnwB, selB, gntB;
    logic [47:0] abusB;
    logic [31:0] dbusB;
    logic [11:0] habusB;
    logic        hrnwB, hselB, xopenB;
    logic [7:0]  hdbusB;

    int total = 0;
    int bad   = 0;

    int ownA = -1, ptrA = 0, ownB = -1, ptrB = 0;
    bit prevA = 0, openA = 0, prevB = 0, openB = 0;

    hba_arbiter #(.NUM_MASTERS(2)) dut_a (
        .hba_clk(hba_clk), .hba_reset(rst), .master_request(reqA), .master_abus(abusA),
        .master_rnw(rnwA), .master_select(selA), .master_dbus(dbusA), .hba_mgrant(gntA),
        .hba_abus(habusA), .hba_rnw(hrnwA), .hba_select(hselA), .hba_dbus(hdbusA),
        .hba_xferack(ack), .o_xfer_open(xopenA)
    );

    hba_arbiter #(.NUM_MASTERS(4)) dut_b (
        .hba_clk(hba_clk), .hba_reset(rst), .master_request(reqB), .master_abus(abusB),
        .master_rnw(rnwB), .master_select(selB), .master_dbus(dbusB), .hba_mgrant(gntB),
        .hba_abus(habusB), .hba_rnw(hrnwB), .hba_select(hselB), .hba_dbus(hdbusB),
        .hba_xferack(1'b0), .o_xfer_open(xopenB)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arbitration rules: scan upward from the pointer in IDLE; release only when
    // the owner has neither request nor select; pointer moves past the owner.
    task automatic mdl_edge(input int n, input bit r, input logic [7:0] req,
                            input logic [7:0] sel, input bit ak,
                            inout int own, inout int ptr, inout bit prev, inout bit open);
        bit so;
        so = (own >= 0) ? sel[own] : 1'b0;
        if (r) begin
            own = -1; ptr = 0; prev = 0; open = 0;
        end else begin
            if (so && !ak) open = prev ? open : 1'b1;
            else           open = 1'b0;
            prev = so;
            if (own < 0) begin
                for (int k = 0; k < n; k++)
                    if (req[(ptr + k) % n]) begin own = (ptr + k) % n; break; end
            end else if (!req[own] && !sel[own]) begin
                ptr = (own + 1) % n;
                own = -1;
            end
        end
    endtask

    task automatic step();
        #2;
        chk("onehotA", {63'd0, $onehot0(gntA)}, 64'd1);
        chk("onehotB", {63'd0, $onehot0(gntB)}, 64'd1);
        chk("gntA",   gntA,   (ownA >= 0) ? (64'd1 << ownA) : 64'd0);
        chk("abusA",  habusA, (ownA >= 0) ? abusA[ownA*12 +: 12] : 12'd0);
        chk("rnwA",   hrnwA,  (ownA >= 0) ? rnwA[ownA] : 1'b0);
        chk("selA",   hselA,  (ownA >= 0) ? selA[ownA] : 1'b0);
        chk("dbusA",  hdbusA, (ownA >= 0) ? dbusA[ownA*8 +: 8] : 8'd0);
        chk("xopenA", xopenA, openA);
        chk("gntB",   gntB,   (ownB >= 0) ? (64'd1 << ownB) : 64'd0);
        chk("abusB",  habusB, (ownB >= 0) ? abusB[ownB*12 +: 12] : 12'd0);
        chk("rnwB",   hrnwB,  (ownB >= 0) ? rnwB[ownB] : 1'b0);
        chk("selB",   hselB,  (ownB >= 0) ? selB[ownB] : 1'b0);
        chk("dbusB",  hdbusB, (ownB >= 0) ? dbusB[ownB*8 +: 8] : 8'd0);
        chk("xopenB", xopenB, openB);
        @(posedge hba_clk);
        mdl_edge(2, rst, {6'd0, reqA}, {6'd0, selA}, ack, ownA, ptrA, prevA, openA);
        mdl_edge(4, rst, {4'd0, reqB}, {4'd0, selB}, 1'b0, ownB, ptrB, prevB, openB);
        #1;
    endtask

    int order [$];
    int exp_order [5];

    initial begin
        rst = 1'b1; ack = 1'b0;
        reqA = '0; selA = '0; rnwA = 2'b01;
        abusA = {12'h345, 12'h012}; dbusA = {8'h5A, 8'hA5};
        reqB = '0; selB = '0; rnwB = 4'b1010;
        abusB = {12'h444, 12'h333, 12'h222, 12'h111}; dbusB = 32'h44332211;
        @(posedge hba_clk); @(posedge hba_clk); #1;

        // reset state
        step();
        chk("rst_gnt", gntA, 2'b00);
        chk("rst_abus", habusA, 12'h000);
        rst = 1'b0;

        // single requester
        reqA = 2'b01; step();
        chk("r032_gnt", gntA, 2'b01);
        chk("r032_abus", habusA, 12'h012);

        // simultaneous requests from reset
        rst = 1'b1; step(); rst = 1'b0;
        reqA = 2'b11; step();
        chk("r033_first", gntA, 2'b01);
        reqA = 2'b10; step();
        chk("r033_dead", gntA, 2'b00);
        step();
        chk("r033_m1", gntA, 2'b10);
        reqA = 2'b01; step();
        chk("r033_dead2", gntA, 2'b00);
        step();
        chk("r033_m0", gntA, 2'b01);

        // request drop deferred by active select
        reqA = 2'b11; selA = 2'b01; step();
        reqA = 2'b10; step();
        chk("r034_held", gntA, 2'b01);
        selA = 2'b00; step();
        chk("r034_rel", gntA, 2'b00);
        step();
        chk("r034_next", gntA, 2'b10);

        // non-owner select has no effect
        abusA = {12'h345, 12'hFFF}; selA = 2'b01; step();
        chk("r035_sel", hselA, 1'b0);
        chk("r035_abus", habusA, 12'h345);
        abusA = {12'h345, 12'h012};

        // reset mid-transfer
        selA = 2'b10; step();
        chk("r036_open", xopenA, 1'b1);
        rst = 1'b1; step();
        chk("r036_gnt", gntA, 2'b00);
        chk("r036_abus", habusA, 12'h000);
        chk("r036_sel", hselA, 1'b0);
        chk("r036_dbus", hdbusA, 8'h00);
        chk("r036_xopen", xopenA, 1'b0);
        rst = 1'b0; reqA = 2'b11; selA = 2'b00; step();
        chk("r036_m0", gntA, 2'b01);

        // acknowledge closes a transfer; select staying high does not reopen it
        selA = 2'b01; step();
        chk("ack_open", xopenA, 1'b1);
        ack = 1'b1; step(); ack = 1'b0;
        chk("ack_close", xopenA, 1'b0);
        step();
        chk("ack_stay", xopenA, 1'b0);
        selA = 2'b00; reqA = 2'b00; step();

        // 4-master rotation, each owner holds for one cycle
        rst = 1'b1; step(); rst = 1'b0;
        for (int s = 0; s < 10; s++) begin
            reqB = 4'hF & ~((ownB >= 0) ? (4'b0001 << ownB) : 4'b0000);
            step();
            for (int i = 0; i < 4; i++) if (gntB[i]) order.push_back(i);
        end
        reqB = '0;
        exp_order = '{0, 1, 2, 3, 0};
        chk("r037_len", order.size(), 5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            chk($sformatf("r037_ord%0d", i), order[i], exp_order[i]);

        // random traffic
        for (int it = 0; it < 400; it++) begin
            rst   = ($urandom_range(0, 31) == 0);
            reqA  = 2'($urandom);
            selA  = 2'($urandom);
            ack   = ($urandom_range(0, 3) == 0);
            rnwA  = 2'($urandom);
            abusA = 24'($urandom);
            dbusA = 16'($urandom);
            reqB  = 4'($urandom);
            selB  = 4'($urandom);
            rnwB  = 4'($urandom);
            dbusB = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
